// File: rtl/cfi_log_drain.sv
`default_nettype none
// ============================================================================
// Module : cfi_log_drain
// Desc   : Buffers committed CFI log entries and streams each one as WORD_W
//          words to the external checker, holding it until its verdict.
// Rev    : 1.0 - initial release
// ============================================================================

module cfi_log_drain #(
  parameter int DEPTH     = 8,
  parameter int LOG_WIDTH = 96,
  parameter int WORD_W    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     queue_push_i,
  input  logic [LOG_WIDTH-1:0]     queue_data_i,
  output logic                     queue_full_o,
  output logic                     req_valid_o,
  input  logic                     req_ready_i,
  output logic [WORD_W-1:0]        req_data_o,
  output logic                     req_last_o,
  input  logic                     rsp_valid_i,
  input  logic                     rsp_ok_i,
  input  logic                     clear_i,
  output logic                     violation_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   pending_o
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_cnt_w  = c_addr_w + 1;
  localparam int c_nwords = (LOG_WIDTH + WORD_W - 1) / WORD_W;
  localparam int c_wc_w   = (c_nwords > 1) ? $clog2(c_nwords) : 1;
  localparam int c_pad_w  = c_nwords * WORD_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND     = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_FAULT    = 2'd3
  } state_t;

  logic [LOG_WIDTH-1:0] r_mem [DEPTH];
  logic [c_addr_w-1:0]  r_wr_ptr;
  logic [c_addr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_wc_w-1:0]    r_wc;
  state_t               r_state;
  logic                 r_violation;
  logic                 r_overflow;

  state_t               w_state_nxt;
  logic [c_wc_w-1:0]    w_wc_nxt;
  logic [c_cnt_w-1:0]   w_count_nxt;
  logic                 w_pop;
  logic                 w_push_ok;
  logic                 w_set_viol;
  logic                 w_clr_viol;
  logic                 w_last;
  logic [c_pad_w-1:0]   w_head_pad;

  assign w_last    = (r_wc == c_wc_w'(c_nwords - 1));
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still fits.
  assign w_push_ok = queue_push_i && ((r_count < c_cnt_w'(DEPTH)) || w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_wc_nxt    = r_wc;
    w_pop       = 1'b0;
    w_set_viol  = 1'b0;
    w_clr_viol  = 1'b0;
    req_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = S_SEND;
          w_wc_nxt    = '0;
        end
      end
      S_SEND: begin
        req_valid_o = 1'b1;
        if (req_ready_i) begin
          if (w_last) begin
            w_state_nxt = S_WAIT_RSP;
            w_wc_nxt    = '0;
          end else begin
            w_wc_nxt = r_wc + c_wc_w'(1);
          end
        end
      end
      S_WAIT_RSP: begin
        if (rsp_valid_i) begin
          if (rsp_ok_i) begin
            w_pop       = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_set_viol  = 1'b1;
            w_state_nxt = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        if (clear_i) begin
          w_pop       = 1'b1;
          w_clr_viol  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_nxt = r_count + c_cnt_w'(1);
    end else if (!w_push_ok && w_pop) begin
      w_count_nxt = r_count - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_wc        <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_violation <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wc    <= w_wc_nxt;
      r_count <= w_count_nxt;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
      if (w_set_viol) begin
        r_violation <= 1'b1;
      end else if (w_clr_viol) begin
        r_violation <= 1'b0;
      end
      if (queue_push_i && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset: pointers and count alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= queue_data_i;
    end
  end

  always_comb begin
    w_head_pad                = '0;
    w_head_pad[LOG_WIDTH-1:0] = r_mem[r_rd_ptr];
  end

  assign req_data_o   = (r_state == S_SEND) ? w_head_pad[r_wc*WORD_W +: WORD_W] : '0;
  assign req_last_o   = (r_state == S_SEND) && w_last;
  assign queue_full_o = (r_count == c_cnt_w'(DEPTH));
  assign pending_o    = r_count;
  assign violation_o  = r_violation;
  assign overflow_o   = r_overflow;

endmodule

`default_nettype wire
